operand_fetch: RTL and testbench
================================

Name: operand_fetch

Overview:
- Issue stage directly upstream of the 32x32 regfile.
- Accepts decoded instructions over a valid/ready handshake and drives the regfile read addresses. Captures both read operands, with bypass from the writeback bus, into a one-entry output register for the execute stage.
- Keeps a pending-write scoreboard and stalls on RAW and WAW hazards.
- Register x0 always reads zero and is never tracked.

Parameters:
- DATA_W, 32, operand and writeback data width.
- ADDR_W, 5, register address width; the register count is 2**ADDR_W.

Ports:
- clock  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_rs1  in  ADDR_W  source register 1.
- in_rs2  in  ADDR_W  source register 2.
- in_rd  in  ADDR_W  destination register.
- in_rd_en  in  1  instruction writes in_rd.
- ra1  out  ADDR_W  regfile read address 1.
- ra2  out  ADDR_W  regfile read address 2.
- rd1  in  DATA_W  regfile read data 1 (combinational).
- rd2  in  DATA_W  regfile read data 2 (combinational).
- wb_en  in  1  writeback strobe; shared with the regfile Enable.
- wb_addr  in  ADDR_W  writeback address; shared with the regfile wa3.
- wb_data  in  DATA_W  writeback data; shared with the regfile Writein.
- out_valid  out  1  operands valid to execute.
- out_ready  in  1  execute consumes this cycle.
- out_op1  out  DATA_W  operand 1.
- out_op2  out  DATA_W  operand 2.
- out_rd  out  ADDR_W  destination register passed downstream.
- out_rd_en  out  1  destination write enable passed downstream.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - out_valid=0; out_op1, out_op2, out_rd and out_rd_en all 0; scoreboard cleared.
  - in_ready follows its equation immediately, so it is 1 whenever no hazard applies.
- Read addresses: ra1=in_rs1 and ra2=in_rs2 combinationally, every cycle, regardless of in_valid.
- Operand select, per source s:
  - s==0: operand is 0.
  - Otherwise, if wb_en and wb_addr==s: operand is wb_data (same-cycle bypass, because the regfile write lands at the same edge).
  - Otherwise: operand is the regfile read data.
- Scoreboard:
  - One pending bit per register; bit 0 is hardwired 0.
  - A source or destination r (r≠0) is "busy" if pend[r]=1 and NOT (wb_en and wb_addr==r).
- Hazard: in_rs1 busy, OR in_rs2 busy, OR (in_rd_en and in_rd busy).
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hazard.
  - in_ready may depend on in_rs1, in_rs2, in_rd and in_rd_en, but never on in_valid.
  - Accept happens when in_valid && in_ready.
- On accept:
  - The output register loads the selected operands, in_rd and in_rd_en, and sets out_valid=1 at the next edge. Latency is 1 cycle.
  - If in_rd_en and in_rd≠0, pend[in_rd] is set.
- Output register:
  - If out_valid && out_ready and no accept that cycle, out_valid becomes 0 and data is held.
  - If out_valid && !out_ready, all out_* are held stable; in_ready is 0.
  - Back-to-back accept with out_ready=1 sustains 1 instruction per cycle.
- Scoreboard clear: wb_en && wb_addr≠0 clears pend[wb_addr].
  - If set and clear hit the same bit in the same cycle, set wins.
- wb_en with wb_addr=0 is ignored by the scoreboard and by the bypass.
- Writeback to a non-pending register only updates the bypass path; the scoreboard is unchanged.
- Reset mid-operation: the in-flight output is dropped and all pending bits are lost. The surrounding pipeline is reset together with this stage.

Test Plan:
1. Reset, then issue rs1=3, rs2=4, rd=5, rd_en=1 with regfile x3=0x11, x4=0x22 and out_ready=1.
   -> ra1=3 and ra2=4 the same cycle; the next cycle shows out_valid=1, op1=0x11, op2=0x22, out_rd=5, and pend[5]=1.
2. With pend[5]=1, present rs1=5.
   -> in_ready=0, and it holds until wb_en=1, wb_addr=5, wb_data=0xABCD. That cycle in_ready=1; the next cycle op1=0xABCD and pend[5]=0.
3. Issue rs1=0, rs2=0 while the regfile returns 0xFFFF_FFFF, together with wb_en=1, wb_addr=0.
   -> op1=op2=0; the scoreboard is unchanged.
4. Issue rd=7 while a writeback to x7 clears it in the same cycle, with in_rd_en=1.
   -> accepted; pend[7] ends at 1 (set wins).
5. Hold out_ready=0 for 3 cycles with a second instruction valid.
   -> out_* stable, in_ready=0. Release -> the second instruction appears on the cycle after out_ready=1.
6. Assert reset_n=0 asynchronously mid-clock while out_valid=1 and pend[9]=1.
   -> out_valid=0 immediately; after release, rs1=9 is accepted without a stall.

Source files
------------

// File: rtl/operand_fetch.sv
// Issue stage: reads regfile operands (with writeback bypass) into a one-entry output register.
// Latency 1 cycle; stalls on RAW/WAW via a pending-write scoreboard or when the held output is not consumed.
module operand_fetch #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic              in_rd_en,
    output logic [ADDR_W-1:0] ra1,
    output logic [ADDR_W-1:0] ra2,
    input  logic [DATA_W-1:0] rd1,
    input  logic [DATA_W-1:0] rd2,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [ADDR_W-1:0] out_rd,
    output logic              out_rd_en
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0]   pend_q, pend_d;
    logic [NREG-1:0]   wb_clr;
    logic [NREG-1:0]   pend_eff;
    logic              hazard;
    logic              accept;
    logic [DATA_W-1:0] op1_sel, op2_sel;

    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_op1_q, out_op1_d;
    logic [DATA_W-1:0] out_op2_q, out_op2_d;
    logic [ADDR_W-1:0] out_rd_q, out_rd_d;
    logic              out_rd_en_q, out_rd_en_d;

    // Writeback to r lands at the same edge, so r is already usable this cycle.
    function automatic logic [DATA_W-1:0] sel_operand(
        input logic [ADDR_W-1:0] src,
        input logic [DATA_W-1:0] rf_data,
        input logic              wen,
        input logic [ADDR_W-1:0] waddr,
        input logic [DATA_W-1:0] wdata
    );
        if (src == '0)
            return '0;
        else if (wen && (waddr == src))
            return wdata;
        else
            return rf_data;
    endfunction

    assign ra1 = in_rs1;
    assign ra2 = in_rs2;

    always_comb begin
        wb_clr = '0;
        if (wb_en && (wb_addr != '0))
            wb_clr[wb_addr] = 1'b1;
        pend_eff = pend_q & ~wb_clr;
        hazard   = pend_eff[in_rs1] | pend_eff[in_rs2] | (in_rd_en & pend_eff[in_rd]);
        in_ready = (!out_valid_q || out_ready) && !hazard;
        accept   = in_valid && in_ready;
        op1_sel  = sel_operand(in_rs1, rd1, wb_en, wb_addr, wb_data);
        op2_sel  = sel_operand(in_rs2, rd2, wb_en, wb_addr, wb_data);
    end

    // Clear first, then set, so a same-cycle set on the same register wins.
    always_comb begin
        pend_d = pend_eff;
        if (accept && in_rd_en && (in_rd != '0))
            pend_d[in_rd] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_op1_d   = out_op1_q;
        out_op2_d   = out_op2_q;
        out_rd_d    = out_rd_q;
        out_rd_en_d = out_rd_en_q;
        if (accept) begin
            out_valid_d = 1'b1;
            out_op1_d   = op1_sel;
            out_op2_d   = op2_sel;
            out_rd_d    = in_rd;
            out_rd_en_d = in_rd_en;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_q      <= '0;
            out_valid_q <= 1'b0;
            out_op1_q   <= '0;
            out_op2_q   <= '0;
            out_rd_q    <= '0;
            out_rd_en_q <= 1'b0;
        end else begin
            pend_q      <= pend_d;
            out_valid_q <= out_valid_d;
            out_op1_q   <= out_op1_d;
            out_op2_q   <= out_op2_d;
            out_rd_q    <= out_rd_d;
            out_rd_en_q <= out_rd_en_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_op1   = out_op1_q;
    assign out_op2   = out_op2_q;
    assign out_rd    = out_rd_q;
    assign out_rd_en = out_rd_en_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: directed vector table, hand-written stall/reset sequences, random run vs a set-based model.
module tb_operand_fetch;

    logic        clock;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_rd_en;
    logic [4:0]  ra1, ra2;
    logic [31:0] rd1, rd2;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_op1, out_op2;
    logic [4:0]  out_rd;
    logic        out_rd_en;

    logic [31:0] rf [32];
    logic        force_ff;

    assign rd1 = force_ff ? 32'hFFFF_FFFF : rf[ra1];
    assign rd2 = force_ff ? 32'hFFFF_FFFF : rf[ra2];

    operand_fetch #(.DATA_W(32), .ADDR_W(5)) dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_rd_en(in_rd_en),
        .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd), .out_rd_en(out_rd_en)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    // Reference model: pending registers kept as a plain set (queue of indices).
    int          m_pend[$];
    logic        m_valid;
    logic [31:0] m_op1, m_op2;
    logic [4:0]  m_rd;
    logic        m_rd_en;

    typedef struct {
        logic        v;
        logic [4:0]  rs1, rs2, rd;
        logic        rd_en, wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        ff;
        logic        exp_rdy, exp_valid;
        logic [31:0] exp_op1, exp_op2;
        logic [4:0]  exp_rd;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_is_pending(input int r);
        foreach (m_pend[i]) if (m_pend[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_busy(input int r, input bit wen, input int wa);
        return (r != 0) && m_is_pending(r) && !(wen && wa == r);
    endfunction

    function automatic logic [31:0] m_operand(input int s, input bit wen, input int wa,
                                              input logic [31:0] wd, input bit ff);
        if (s == 0) return 32'h0;
        if (wen && wa == s) return wd;
        return ff ? 32'hFFFF_FFFF : rf[s];
    endfunction

    task automatic m_reset();
        m_pend.delete();
        m_valid = 1'b0; m_op1 = '0; m_op2 = '0; m_rd = '0; m_rd_en = 1'b0;
    endtask

    // One clock: drive, check combinational outputs, advance model, check registered outputs.
    task automatic step(input bit v, input int rs1, input int rs2, input int rd, input bit rd_en,
                        input bit wen, input int wa, input logic [31:0] wd, input bit ordy,
                        input bit ff, output bit rdy_seen);
        bit exp_rdy;
        bit acc;
        logic [31:0] n1, n2;
        in_valid = v; in_rs1 = 5'(rs1); in_rs2 = 5'(rs2); in_rd = 5'(rd); in_rd_en = rd_en;
        wb_en = wen; wb_addr = 5'(wa); wb_data = wd; out_ready = ordy; force_ff = ff;
        #1;
        exp_rdy = (!m_valid || ordy) && !m_busy(rs1, wen, wa) && !m_busy(rs2, wen, wa)
                  && !(rd_en && m_busy(rd, wen, wa));
        check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        check("ra1", {27'b0, ra1}, 32'(rs1));
        check("ra2", {27'b0, ra2}, 32'(rs2));
        rdy_seen = in_ready;
        acc = v && exp_rdy;
        n1 = m_operand(rs1, wen, wa, wd, ff);
        n2 = m_operand(rs2, wen, wa, wd, ff);
        if (wen && wa != 0)
            foreach (m_pend[i]) if (m_pend[i] == wa) begin m_pend.delete(i); break; end
        if (acc && rd_en && rd != 0 && !m_is_pending(rd)) m_pend.push_back(rd);
        if (acc) begin
            m_valid = 1'b1; m_op1 = n1; m_op2 = n2; m_rd = 5'(rd); m_rd_en = rd_en;
        end else if (ordy) begin
            m_valid = 1'b0;
        end
        @(posedge clock);
        #1;
        if (wen && wa != 0) rf[wa] = wd;
        check("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        check("out_op1", out_op1, m_op1);
        check("out_op2", out_op2, m_op2);
        check("out_rd", {27'b0, out_rd}, {27'b0, m_rd});
        check("out_rd_en", {31'b0, out_rd_en}, {31'b0, m_rd_en});
    endtask

    function automatic vec_t mk(input bit v, input int rs1, input int rs2, input int rd, input bit rd_en,
                                input bit wen, input int wa, input logic [31:0] wd, input bit ff,
                                input bit erdy, input bit evld, input logic [31:0] e1,
                                input logic [31:0] e2, input int erd);
        vec_t t;
        t.v = v; t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.rd = 5'(rd); t.rd_en = rd_en;
        t.wen = wen; t.wa = 5'(wa); t.wd = wd; t.ff = ff;
        t.exp_rdy = erdy; t.exp_valid = evld; t.exp_op1 = e1; t.exp_op2 = e2; t.exp_rd = 5'(erd);
        return t;
    endfunction

    initial begin
        bit rdy;
        for (int i = 0; i < 32; i++) rf[i] = 32'h1000 + i;
        rf[0] = 32'h0; rf[3] = 32'h11; rf[4] = 32'h22;

        //       v rs1 rs2 rd en wen wa wd            ff rdy vld op1           op2           rd
        vecs[0]  = mk(1, 3, 4, 5, 1, 0, 0, 32'h0,         0, 1, 1, 32'h11,      32'h22,      5);
        vecs[1]  = mk(1, 5, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h11,      32'h22,      5);
        vecs[2]  = mk(1, 5, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h11,      32'h22,      5);
        vecs[3]  = mk(1, 5, 0, 0, 0, 1, 5, 32'hABCD,      0, 1, 1, 32'hABCD,    32'h0,       0);
        vecs[4]  = mk(1, 5, 5, 0, 0, 0, 0, 32'h0,         0, 1, 1, 32'hABCD,    32'hABCD,    0);
        vecs[5]  = mk(1, 0, 0, 0, 0, 1, 0, 32'h1234,      1, 1, 1, 32'h0,       32'h0,       0);
        vecs[6]  = mk(1, 1, 2, 7, 1, 0, 0, 32'h0,         0, 1, 1, 32'h1001,    32'h1002,    7);
        vecs[7]  = mk(1, 0, 0, 7, 1, 1, 7, 32'h7777,      0, 1, 1, 32'h0,       32'h0,       7);
        vecs[8]  = mk(1, 7, 0, 0, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0,       32'h0,       7);
        vecs[9]  = mk(0, 7, 0, 0, 0, 1, 7, 32'h99,        0, 1, 0, 32'h0,       32'h0,       7);
        vecs[10] = mk(1, 0, 0, 9, 1, 0, 0, 32'h0,         0, 1, 1, 32'h0,       32'h0,       9);
        vecs[11] = mk(1, 0, 0, 9, 1, 0, 0, 32'h0,         0, 0, 0, 32'h0,       32'h0,       9);
        vecs[12] = mk(1, 0, 0, 9, 0, 0, 0, 32'h0,         0, 1, 1, 32'h0,       32'h0,       9);

        reset_n = 1'b0; in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_rd_en = 0;
        wb_en = 0; wb_addr = 0; wb_data = 0; out_ready = 1; force_ff = 0;
        m_reset();
        #3;
        check("reset out_valid", {31'b0, out_valid}, 32'h0);
        check("reset out_op1", out_op1, 32'h0);
        check("reset out_op2", out_op2, 32'h0);
        check("reset out_rd", {27'b0, out_rd}, 32'h0);
        check("reset out_rd_en", {31'b0, out_rd_en}, 32'h0);
        check("reset in_ready", {31'b0, in_ready}, 32'h1);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        for (int i = 0; i < 13; i++) begin
            step(vecs[i].v, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].rd_en, vecs[i].wen,
                 vecs[i].wa, vecs[i].wd, 1'b1, vecs[i].ff, rdy);
            check($sformatf("vec%0d in_ready", i), {31'b0, rdy}, {31'b0, vecs[i].exp_rdy});
            check($sformatf("vec%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
            check($sformatf("vec%0d out_op1", i), out_op1, vecs[i].exp_op1);
            check($sformatf("vec%0d out_op2", i), out_op2, vecs[i].exp_op2);
            check($sformatf("vec%0d out_rd", i), {27'b0, out_rd}, {27'b0, vecs[i].exp_rd});
        end

        // Asynchronous reset mid-cycle while out_valid=1 and x9 pending.
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst out_valid", {31'b0, out_valid}, 32'h0);
        check("async rst out_rd", {27'b0, out_rd}, 32'h0);
        m_reset();
        #3;
        reset_n = 1'b1;
        step(1, 9, 0, 0, 0, 0, 0, 32'h0, 1, 0, rdy);
        check("post-reset rs1=9 ready", {31'b0, rdy}, 32'h1);

        // Output held for three cycles with a second instruction waiting.
        step(1, 1, 2, 0, 0, 0, 0, 32'h0, 1, 0, rdy);
        for (int k = 0; k < 3; k++) begin
            step(1, 3, 4, 6, 1, 0, 0, 32'h0, 0, 0, rdy);
            check($sformatf("hold%0d in_ready", k), {31'b0, rdy}, 32'h0);
            check($sformatf("hold%0d out_op1", k), out_op1, 32'h1001);
            check($sformatf("hold%0d out_valid", k), {31'b0, out_valid}, 32'h1);
        end
        step(1, 3, 4, 6, 1, 0, 0, 32'h0, 1, 0, rdy);
        check("release in_ready", {31'b0, rdy}, 32'h1);
        check("release out_op1", out_op1, 32'h11);
        check("release out_op2", out_op2, 32'h22);
        check("release out_rd", {27'b0, out_rd}, 32'h6);

        // Random traffic over a small register window to provoke hazards.
        for (int n = 0; n < 400; n++) begin
            step(bit'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 $urandom_range(0, 7), $urandom, ($urandom_range(0, 3) != 0), 0, rdy);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
